alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_sequencer                                                |
// | Description : Issues one operation at a time to a registered external ALU, |
// |               pads multiply/divide with MULDIV_WAIT cycles and holds the    |
// |               result until the consumer takes it.                          |
// |               Optional macro ALU_SEQ_ILLEGAL_TRAP_EN traps opcodes 0 / F.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_sequencer #(
    parameter int MULDIV_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  op_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [63:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_err
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ISSUE   = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_CAPTURE = 3'd3;
    localparam logic [2:0] c_ST_RESP    = 3'd4;

    localparam int                 c_CNT_W     = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'((MULDIV_WAIT > 0) ? MULDIV_WAIT - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [3:0]         r_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_is_muldiv;

    assign w_is_muldiv = (r_sel == 4'b0011) || (r_sel == 4'b0100);

    always_comb begin
        w_next   = r_state;
        op_ready = 1'b0;
        alu_sel  = 4'b0000;
        case (r_state)
            c_ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    w_next = ((op_sel == 4'b0000) || (op_sel == 4'b1111)) ? c_ST_CAPTURE : c_ST_ISSUE;
`else
                    w_next = c_ST_ISSUE;
`endif
                end
            end
            c_ST_ISSUE: begin
                alu_sel = r_sel;
                w_next  = (w_is_muldiv && (MULDIV_WAIT > 0)) ? c_ST_WAIT : c_ST_CAPTURE;
            end
            c_ST_WAIT: begin
                if (r_cnt == '0) w_next = c_ST_CAPTURE;
            end
            c_ST_CAPTURE: w_next = c_ST_RESP;
            c_ST_RESP: begin
                if (res_ready) w_next = c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic r_err;
    assign res_err = r_err;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (op_valid) begin
                        r_a   <= op_a;
                        r_b   <= op_b;
                        r_sel <= op_sel;
                    end
                end
                c_ST_ISSUE: begin
                    if (w_next == c_ST_WAIT) r_cnt <= c_WAIT_LOAD;
                end
                c_ST_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_ONE;
                end
                c_ST_CAPTURE: begin
                    // Only mul/div produce a meaningful HI word; anything else the ALU left there is stale.
                    r_lo <= alu_out[31:0];
                    r_hi <= w_is_muldiv ? alu_out[63:32] : 32'h0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    r_err <= 1'b0;
                    if ((r_sel == 4'b0000) || (r_sel == 4'b1111)) begin
                        r_lo  <= 32'h0;
                        r_hi  <= 32'h0;
                        r_err <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign res_valid = (r_state == c_ST_RESP);
    assign res_hi    = r_hi;
    assign res_lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_sequencer                                             |
// | Description : Transaction-level model plus a registered ALU stand-in;      |
// |               directed cases then randomized traffic with resets.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_sequencer;

    localparam int W = 2;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, op_valid, op_ready, res_valid, res_ready, res_err;
    logic [31:0] op_a, op_b, alu_a, alu_b, res_hi, res_lo;
    logic [3:0]  op_sel, alu_sel;
    logic [63:0] alu_out = '0;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(.MULDIV_WAIT(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hi(res_hi), .res_lo(res_lo), .res_err(res_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        case (sel)
            4'd1:    return {32'h0, a + b};
            4'd2:    return {32'h0, a - b};
            4'd3:    return {32'h0, a} * {32'h0, b};
            4'd4:    return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4'd5:    return {32'h0, a & b};
            4'd6:    return {32'h0, a | b};
            4'd7:    return {32'h0, a ^ b};
            default: return {32'h0, a ^ {28'h0, sel}};
        endcase
    endfunction

    // ALU stand-in: registered, holds when unselected, junk in HI for single-word ops.
    always @(posedge clk) begin
        logic [63:0] f;
        if (alu_sel != 4'd0) begin
            f = alu_f(alu_a, alu_b, alu_sel);
            if (alu_sel == 4'd3 || alu_sel == 4'd4) alu_out <= f;
            else                                    alu_out <= {$urandom, f[31:0]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: age counts cycles since the accept cycle.
    bit          seen_rst = 1'b0;
    bit          m_busy = 1'b0, m_trap = 1'b0;
    int          m_age = 0, m_lat = 3;
    logic [31:0] m_a = '0, m_b = '0, e_hi = '0, e_lo = '0, m_hi = '0, m_lo = '0;
    logic [3:0]  m_sel = '0;
    logic        e_err = 1'b0, m_err = 1'b0;

    always @(negedge clk) begin
        logic [63:0] f;
        bit md;
        if (seen_rst) begin
            chk("op_ready", op_ready, !m_busy);
            chk("res_valid", res_valid, m_busy && m_age >= m_lat);
            chk("res_hi", res_hi, m_hi);
            chk("res_lo", res_lo, m_lo);
            chk("res_err", res_err, m_err);
            chk("alu_sel", alu_sel, (m_busy && m_age == 1 && !m_trap) ? m_sel : 4'd0);
            if (m_busy && m_age >= 1 && m_age < m_lat) begin
                chk("alu_a", alu_a, m_a);
                chk("alu_b", alu_b, m_b);
            end
        end
        if (reset) begin
            seen_rst = 1'b1;
            m_busy = 1'b0; m_age = 0;
            m_hi = '0; m_lo = '0; m_err = 1'b0;
        end else if (seen_rst) begin
            if (m_busy) begin
                if (m_age >= m_lat) begin
                    if (res_ready) m_busy = 1'b0;
                end else begin
                    m_age++;
                    if (m_age == m_lat) begin
                        m_hi = e_hi; m_lo = e_lo; m_err = e_err;
                    end
                end
            end else if (op_valid) begin
                m_busy = 1'b1; m_age = 0;
                m_a = op_a; m_b = op_b; m_sel = op_sel;
                m_trap = TRAP_EN && (op_sel == 4'd0 || op_sel == 4'd15);
                md = (op_sel == 4'd3 || op_sel == 4'd4);
                m_lat = m_trap ? 2 : ((md && W > 0) ? 3 + W : 3);
                f = alu_f(op_a, op_b, op_sel);
                e_lo  = m_trap ? 32'h0 : f[31:0];
                e_hi  = (m_trap || !md) ? 32'h0 : f[63:32];
                e_err = m_trap;
                m_age = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          input int hold, input string name,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo, output logic err);
        int n;
        op_a = a; op_b = b; op_sel = sel; op_valid = 1'b1; res_ready = 1'b0;
        n = 0;
        while (!op_ready && n < 40) begin step(); n++; end
        step();
        op_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin step(); lat++; end
        if (!res_valid) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no res_valid expected res_valid within 40 cycles", name);
        end
        hi = res_hi; lo = res_lo; err = res_err;
        for (int i = 0; i < hold; i++) begin
            step();
            chk({name, "_hold_valid"}, res_valid, 1'b1);
            chk({name, "_hold_lo"}, res_lo, lo);
            chk({name, "_hold_ready"}, op_ready, 1'b0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({name, "_post_valid"}, res_valid, 1'b0);
        chk({name, "_post_ready"}, op_ready, 1'b1);
    endtask

    initial begin
        int          lat, n;
        logic [31:0] hi, lo;
        logic        err;
        logic [3:0]  s;

        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_sel = '0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_res_hi", res_hi, 32'h0);
        chk("rst_res_lo", res_lo, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_sel", alu_sel, 4'h0);

        run_op(32'd5, 32'd7, 4'd1, 0, "add", lat, hi, lo, err);
        chk("add_lat", lat, 3); chk("add_lo", lo, 32'd12); chk("add_hi", hi, 32'd0);

        run_op(32'h0001_0000, 32'h0001_0000, 4'd3, 0, "mul", lat, hi, lo, err);
        chk("mul_lat", lat, 5); chk("mul_hi", hi, 32'd1); chk("mul_lo", lo, 32'd0);

        run_op(32'd10, 32'd3, 4'd2, 4, "sub", lat, hi, lo, err);
        chk("sub_lo", lo, 32'd7);

        run_op(32'd17, 32'd5, 4'd4, 0, "div", lat, hi, lo, err);
        chk("div_lo", lo, 32'd3); chk("div_hi", hi, 32'd2);

        run_op(32'd9, 32'd4, 4'd15, 0, "ill", lat, hi, lo, err);
        chk("ill_err", err, TRAP_EN);
        chk("ill_lat", lat, TRAP_EN ? 2 : 3);

        // Reset while the divide sits in its wait cycles.
        op_a = 32'd100; op_b = 32'd7; op_sel = 4'd4; op_valid = 1'b1;
        step(); op_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rmid_valid", res_valid, 1'b0);
        chk("rmid_sel", alu_sel, 4'd0);
        reset = 1'b0;
        chk("rmid_ready", op_ready, 1'b1);
        run_op(32'd1, 32'd1, 4'd1, 0, "radd", lat, hi, lo, err);
        chk("radd_lo", lo, 32'd2);

        // Back-to-back with op_valid held and res_ready high.
        op_a = 32'hF0F0; op_b = 32'hFF00; op_sel = 4'd5; op_valid = 1'b1; res_ready = 1'b1;
        step();
        op_a = 32'h1; op_b = 32'h2; op_sel = 4'd6;
        n = 0;
        while (!res_valid && n < 40) begin step(); n++; end
        chk("b2b_and_lo", res_lo, 32'hF000);
        step();
        chk("b2b_accept", op_ready, 1'b1);
        step();
        op_valid = 1'b0;
        chk("b2b_busy", op_ready, 1'b0);
        n = 0;
        while (!res_valid && n < 40) begin step(); n++; end
        chk("b2b_or_lo", res_lo, 32'h3);
        step();
        res_ready = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) s = 4'(3 + $urandom_range(0, 1));
            if (!TRAP_EN && s == 4'd0) s = 4'd1;
            op_sel    = s;
            op_a      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            op_b      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            op_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
